// File: rtl/oerv_immdec_p.sv
// Immediate decoder that captures an instruction word and streams its 32-bit
// immediate (and the CSR zimm field) W bits per beat, LSB-first.
module oerv_immdec_p #(
  parameter int W = 8
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_wb_en,
  input  logic [31:7] i_wb_rdt,
  input  logic [2:0]  i_imm_type,
  input  logic        i_cnt_en,
  output logic [4:0]  o_rd_addr,
  output logic [4:0]  o_rs1_addr,
  output logic [4:0]  o_rs2_addr,
  output logic [W-1:0] o_imm,
  output logic [W-1:0] o_csr_imm,
  output logic        o_valid,
  output logic        o_last
);

  localparam int NB = 32 / W;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(NB - 1);

  typedef enum logic {
    ST_IDLE,
    ST_STREAM
  } state_t;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5
  } fmt_t;

  state_t        state_q;
  logic [BW-1:0] beat_q;
  logic [31:7]   word_q;
  logic [2:0]    fmt_q;

  logic [31:0]   imm;
  logic [31:0]   imm_win;
  logic [31:0]   csr_win;

  // Reset outranks load, and load outranks advance, so an abort or a
  // same-edge load simply restarts the stream at beat 0.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments only; the reset
    // branch is synchronous, so it lives inside the clocked block.
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
      word_q  <= '0;
      fmt_q   <= FMT_NONE;
    end else if (i_wb_en) begin
      state_q <= ST_STREAM;
      beat_q  <= '0;
      word_q  <= i_wb_rdt;
      fmt_q   <= i_imm_type;
    end else if (i_cnt_en && state_q == ST_STREAM) begin
      if (beat_q == LAST_BEAT) begin
        state_q <= ST_IDLE;
        beat_q  <= '0;
      end else begin
        beat_q  <= beat_q + 1'b1;
      end
    end
  end

  always_comb begin
    // NOTE: default first so every path assigns imm and no latch is inferred.
    imm = '0;
    case (fmt_q)
      FMT_I:   imm = {{20{word_q[31]}}, word_q[31:20]};
      FMT_S:   imm = {{20{word_q[31]}}, word_q[31:25], word_q[11:7]};
      FMT_B:   imm = {{19{word_q[31]}}, word_q[31], word_q[7], word_q[30:25],
                      word_q[11:8], 1'b0};
      FMT_U:   imm = {word_q[31:12], 12'b0};
      FMT_J:   imm = {{11{word_q[31]}}, word_q[31], word_q[19:12], word_q[20],
                      word_q[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

  // Bring the current beat down to bit 0 so the output is a fixed low slice.
  assign imm_win = imm >> (int'(beat_q) * W);
  assign csr_win = {27'b0, word_q[19:15]} >> (int'(beat_q) * W);

  assign o_valid    = (state_q == ST_STREAM);
  assign o_last     = o_valid && (beat_q == LAST_BEAT);
  assign o_imm      = o_valid ? imm_win[W-1:0] : '0;
  assign o_csr_imm  = o_valid ? csr_win[W-1:0] : '0;

  assign o_rd_addr  = word_q[11:7];
  assign o_rs1_addr = word_q[19:15];
  assign o_rs2_addr = word_q[24:20];

endmodule

// File: tb/tb_oerv_immdec_p.sv
// Bench for oerv_immdec_p: three instances (W=8,4,1) share stimulus and are
// checked against a table of known encodings and a format-level model.
module tb_oerv_immdec_p;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_en;
  logic [31:7] wb_rdt;
  logic [2:0]  imm_type;
  logic        cnt_en;

  logic [4:0] rd_8, rs1_8, rs2_8, rd_4, rs1_4, rs2_4, rd_1, rs1_1, rs2_1;
  logic [7:0] imm_8, csr_8;
  logic [3:0] imm_4, csr_4;
  logic [0:0] imm_1, csr_1;
  logic       valid_8, last_8, valid_4, last_4, valid_1, last_1;

  always #5 clk = ~clk;

  oerv_immdec_p #(.W(8)) u_w8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_wb_en(wb_en), .i_wb_rdt(wb_rdt),
    .i_imm_type(imm_type), .i_cnt_en(cnt_en), .o_rd_addr(rd_8),
    .o_rs1_addr(rs1_8), .o_rs2_addr(rs2_8), .o_imm(imm_8), .o_csr_imm(csr_8),
    .o_valid(valid_8), .o_last(last_8));

  oerv_immdec_p #(.W(4)) u_w4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_wb_en(wb_en), .i_wb_rdt(wb_rdt),
    .i_imm_type(imm_type), .i_cnt_en(cnt_en), .o_rd_addr(rd_4),
    .o_rs1_addr(rs1_4), .o_rs2_addr(rs2_4), .o_imm(imm_4), .o_csr_imm(csr_4),
    .o_valid(valid_4), .o_last(last_4));

  oerv_immdec_p #(.W(1)) u_w1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_wb_en(wb_en), .i_wb_rdt(wb_rdt),
    .i_imm_type(imm_type), .i_cnt_en(cnt_en), .o_rd_addr(rd_1),
    .o_rs1_addr(rs1_1), .o_rs2_addr(rs2_1), .o_imm(imm_1), .o_csr_imm(csr_1),
    .o_valid(valid_1), .o_last(last_1));

  // Per-instance views, index 0..2 <-> W = 8, 4, 1.
  logic [31:0] imm_o[3], csr_o[3];
  logic [4:0]  rd_o[3], rs1_o[3], rs2_o[3];
  logic        valid_o[3], last_o[3];

  assign imm_o[0] = {24'h0, imm_8};
  assign imm_o[1] = {28'h0, imm_4};
  assign imm_o[2] = {31'h0, imm_1};
  assign csr_o[0] = {24'h0, csr_8};
  assign csr_o[1] = {28'h0, csr_4};
  assign csr_o[2] = {31'h0, csr_1};
  assign rd_o[0] = rd_8;   assign rd_o[1] = rd_4;   assign rd_o[2] = rd_1;
  assign rs1_o[0] = rs1_8; assign rs1_o[1] = rs1_4; assign rs1_o[2] = rs1_1;
  assign rs2_o[0] = rs2_8; assign rs2_o[1] = rs2_4; assign rs2_o[2] = rs2_1;
  assign valid_o[0] = valid_8; assign valid_o[1] = valid_4; assign valid_o[2] = valid_1;
  assign last_o[0] = last_8;   assign last_o[1] = last_4;   assign last_o[2] = last_1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int width_of(input int k);
    return (k == 0) ? 8 : (k == 1) ? 4 : 1;
  endfunction

  // Immediate value straight from the format's field layout, via signed fields.
  function automatic logic [31:0] ref_imm(input logic [31:0] ins, input logic [2:0] t);
    logic signed [11:0] f12;
    logic signed [12:0] f13;
    logic signed [20:0] f21;
    case (t)
      3'd1: begin f12 = ins[31:20]; return int'(f12); end
      3'd2: begin f12 = {ins[31:25], ins[11:7]}; return int'(f12); end
      3'd3: begin f13 = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}; return int'(f13); end
      3'd4: return ins & 32'hFFFF_F000;
      3'd5: begin f21 = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}; return int'(f21); end
      default: return 32'h0;
    endcase
  endfunction

  // Behavioural model: latched word/format shared, beat position per width.
  logic [31:0] m_word;
  logic [2:0]  m_type;
  bit          m_valid[3];
  int          m_beat[3];

  task automatic model_update();
    if (!rst_n) begin
      m_word = '0;
      m_type = '0;
      for (int k = 0; k < 3; k++) begin m_valid[k] = 0; m_beat[k] = 0; end
    end else if (wb_en) begin
      m_word = {wb_rdt, 7'b0};
      m_type = imm_type;
      for (int k = 0; k < 3; k++) begin m_valid[k] = 1; m_beat[k] = 0; end
    end else if (cnt_en) begin
      for (int k = 0; k < 3; k++) begin
        if (m_valid[k]) begin
          if (m_beat[k] == 32 / width_of(k) - 1) begin
            m_valid[k] = 0;
            m_beat[k]  = 0;
          end else begin
            m_beat[k]++;
          end
        end
      end
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 3; k++) begin
      int          w;
      logic [31:0] mask, e_imm, e_csr;
      w     = width_of(k);
      mask  = (32'h1 << w) - 32'h1;
      e_imm = m_valid[k] ? (ref_imm(m_word, m_type) >> (w * m_beat[k])) & mask : 32'h0;
      e_csr = m_valid[k] ? ({27'h0, m_word[19:15]} >> (w * m_beat[k])) & mask : 32'h0;
      check($sformatf("model_w%0d_imm", w), imm_o[k], e_imm);
      check($sformatf("model_w%0d_csr", w), csr_o[k], e_csr);
      check($sformatf("model_w%0d_valid", w), 32'(valid_o[k]), 32'(m_valid[k]));
      check($sformatf("model_w%0d_last", w), 32'(last_o[k]),
            32'(m_valid[k] && m_beat[k] == 32 / w - 1));
      check($sformatf("model_w%0d_rd", w), 32'(rd_o[k]), 32'(m_word[11:7]));
      check($sformatf("model_w%0d_rs1", w), 32'(rs1_o[k]), 32'(m_word[19:15]));
      check($sformatf("model_w%0d_rs2", w), 32'(rs2_o[k]), 32'(m_word[24:20]));
    end
  endtask

  // Inputs are held across the edge; the model consumes the same values.
  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    compare_all();
  endtask

  task automatic drive(input logic r, input logic ld, input logic [31:0] ins,
                       input logic [2:0] t, input logic ce);
    rst_n    = r;
    wb_en    = ld;
    wb_rdt   = ins[31:7];
    imm_type = t;
    cnt_en   = ce;
  endtask

  typedef struct {
    logic [31:0] ins;
    logic [2:0]  t;
    logic [31:0] imm;
    logic [4:0]  rd, rs1, rs2;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [7:0] abort_exp[4];

    vecs.push_back('{32'hFFF00093, 3'd1, 32'hFFFF_FFFF, 5'd1,  5'd0,  5'd31});
    vecs.push_back('{32'h0020A423, 3'd2, 32'h0000_0008, 5'd8,  5'd1,  5'd2});
    vecs.push_back('{32'hFE000EE3, 3'd3, 32'hFFFF_FFFC, 5'd29, 5'd0,  5'd0});
    vecs.push_back('{32'h12345037, 3'd4, 32'h1234_5000, 5'd0,  5'd8,  5'd3});
    vecs.push_back('{32'h0080006F, 3'd5, 32'h0000_0008, 5'd0,  5'd0,  5'd8});
    vecs.push_back('{32'hFFDFF0EF, 3'd5, 32'hFFFF_FFFC, 5'd1,  5'd31, 5'd29});
    vecs.push_back('{32'h7C0F9073, 3'd1, 32'h0000_07C0, 5'd0,  5'd31, 5'd0});
    vecs.push_back('{32'h80000013, 3'd1, 32'hFFFF_F800, 5'd0,  5'd0,  5'd0});
    vecs.push_back('{32'hFFF00093, 3'd0, 32'h0000_0000, 5'd1,  5'd0,  5'd31});
    vecs.push_back('{32'h0080006F, 3'd7, 32'h0000_0000, 5'd0,  5'd0,  5'd8});

    // Reset edge with a load pending: reset wins, everything reads zero.
    drive(1'b0, 1'b1, 32'hFFF00093, 3'd1, 1'b1);
    step();
    check("rst_valid", 32'(valid_8), 32'h0);
    check("rst_imm", 32'(imm_8), 32'h0);
    check("rst_rd", 32'(rd_8), 32'h0);

    // cnt_en while idle changes nothing.
    drive(1'b1, 1'b0, 32'h0, 3'd1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("idle_cnt_valid", 32'(valid_8), 32'h0);
      check("idle_cnt_imm", 32'(imm_8), 32'h0);
      check("idle_cnt_csr", 32'(csr_8), 32'h0);
    end

    // Table: load, then advance 32 beats; format input scrambled after load.
    foreach (vecs[v]) begin
      drive(1'b1, 1'b1, vecs[v].ins, vecs[v].t, 1'b0);
      step();
      for (int b = 0; b <= 32; b++) begin
        for (int k = 0; k < 3; k++) begin
          int          w, nb;
          logic [31:0] mask, e_imm, e_csr;
          w     = width_of(k);
          nb    = 32 / w;
          mask  = (32'h1 << w) - 32'h1;
          e_imm = (b < nb) ? (vecs[v].imm >> (w * b)) & mask : 32'h0;
          e_csr = (b < nb) ? ({27'h0, vecs[v].rs1} >> (w * b)) & mask : 32'h0;
          check($sformatf("vec%0d_w%0d_b%0d_imm", v, w, b), imm_o[k], e_imm);
          check($sformatf("vec%0d_w%0d_b%0d_csr", v, w, b), csr_o[k], e_csr);
          check($sformatf("vec%0d_w%0d_b%0d_valid", v, w, b), 32'(valid_o[k]), 32'(b < nb));
          check($sformatf("vec%0d_w%0d_b%0d_last", v, w, b), 32'(last_o[k]), 32'(b == nb - 1));
          check($sformatf("vec%0d_w%0d_rd", v, w), 32'(rd_o[k]), 32'(vecs[v].rd));
          check($sformatf("vec%0d_w%0d_rs1", v, w), 32'(rs1_o[k]), 32'(vecs[v].rs1));
          check($sformatf("vec%0d_w%0d_rs2", v, w), 32'(rs2_o[k]), 32'(vecs[v].rs2));
        end
        if (b < 32) begin
          drive(1'b1, 1'b0, $urandom, 3'($urandom_range(0, 7)), 1'b1);
          step();
        end
      end
    end

    // Abort at beat 2 with a U-type load and cnt_en on the same edge.
    abort_exp = '{8'h00, 8'h50, 8'h34, 8'h12};
    drive(1'b1, 1'b1, 32'hFFF00093, 3'd1, 1'b0);
    step();
    drive(1'b1, 1'b0, 32'h0, 3'd1, 1'b1);
    step();
    step();
    check("abort_pre_imm", 32'(imm_8), 32'hFF);
    drive(1'b1, 1'b1, 32'h12345037, 3'd4, 1'b1);
    step();
    for (int b = 0; b < 4; b++) begin
      check($sformatf("abort_b%0d_imm", b), 32'(imm_8), 32'(abort_exp[b]));
      check($sformatf("abort_b%0d_last", b), 32'(last_8), 32'(b == 3));
      drive(1'b1, 1'b0, 32'h0, 3'd0, 1'b1);
      step();
    end
    check("abort_end_valid", 32'(valid_8), 32'h0);

    // Reset mid-stream at beat 2.
    drive(1'b1, 1'b1, 32'h0020A423, 3'd2, 1'b0);
    step();
    drive(1'b1, 1'b0, 32'h0, 3'd2, 1'b1);
    step();
    step();
    drive(1'b0, 1'b1, 32'hFFF00093, 3'd1, 1'b1);
    step();
    check("midrst_valid", 32'(valid_4), 32'h0);
    check("midrst_imm", 32'(imm_1), 32'h0);
    check("midrst_rs2", 32'(rs2_8), 32'h0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      drive(1'($urandom_range(0, 199) != 0), 1'($urandom_range(0, 9) == 0),
            $urandom, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
